// File: rtl/step_pulse_sequencer_pkg.sv
// Shared types and helpers for the step pulse sequencer.
// Default field widths match the top-level parameter defaults.
package step_pulse_sequencer_pkg;

  localparam int unsigned SPS_PERIOD_W = 16;
  localparam int unsigned SPS_COUNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [SPS_PERIOD_W-1:0] period;
    logic [SPS_COUNT_W-1:0]  count;
  } cmd_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/step_pulse_sequencer_period_divider.sv
// Free-running period counter with a loadable modulus; counts 0..mod-1 and wraps.
// Loading also restarts the count at 0; wrap_o flags the last count while enabled.
module step_pulse_sequencer_period_divider #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] mod_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] pc_o,
  output logic         wrap_o
);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] mod_q, mod_d;

  assign wrap_o = en_i && (pc_q == (mod_q - W'(1)));
  assign pc_o   = pc_q;

  always_comb begin
    pc_d  = pc_q;
    mod_d = mod_q;
    if (load_i) begin
      mod_d = mod_i;
      pc_d  = '0;
    end else if (clr_i) begin
      pc_d = '0;
    end else if (en_i) begin
      pc_d = wrap_o ? '0 : pc_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= '0;
      mod_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mod_q <= mod_d;
    end
  end

endmodule

// File: rtl/step_pulse_sequencer.sv
// Command-driven step pulse train generator: count pulses, one every eff_period clocks.
// All outputs registered; a command is taken only in IDLE, abort ends a train after one edge.
module step_pulse_sequencer
  import step_pulse_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD_W = SPS_PERIOD_W,
  parameter int unsigned COUNT_W  = SPS_COUNT_W,
  parameter int unsigned PULSE_W  = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [PERIOD_W-1:0] cmd_period_i,
  input  logic [COUNT_W-1:0]  cmd_count_i,
  input  logic                abort_i,
  output logic                step_o,
  output logic                busy_o,
  output logic [COUNT_W-1:0]  pulses_left_o,
  output logic                done_o,
  output logic                aborted_o
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_W + 1);

  seq_state_t state_q, state_d;
  logic step_q, step_d, busy_q, busy_d, ready_q, ready_d;
  logic done_q, done_d, aborted_q, aborted_d;
  logic [COUNT_W-1:0] pulses_q, pulses_d;

  logic                load, en, clr, wrap;
  logic [PERIOD_W-1:0] eff_period, pc;
  logic                step_next_run;

  // The period can never be shorter than the pulse plus one low clock.
  assign eff_period = (cmd_period_i < MIN_PERIOD) ? MIN_PERIOD : cmd_period_i;

  step_pulse_sequencer_period_divider #(.W(PERIOD_W)) u_div (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .load_i (load),
    .mod_i  (eff_period),
    .en_i   (en),
    .clr_i  (clr),
    .pc_o   (pc),
    .wrap_o (wrap)
  );

  assign step_next_run = wrap || (({1'b0, pc} + 1'b1) < (PERIOD_W+1)'(PULSE_W));

  always_comb begin
    state_d   = state_q;
    step_d    = 1'b0;
    busy_d    = 1'b0;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pulses_d  = pulses_q;
    load      = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid_i && ready_q) begin
          load    = 1'b1;
          ready_d = 1'b0;
          if (cmd_count_i == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            pulses_d = '0;
          end else begin
            state_d  = RUN;
            busy_d   = 1'b1;
            step_d   = 1'b1;
            pulses_d = cmd_count_i - COUNT_W'(1);
          end
        end
      end
      RUN: begin
        en = 1'b1;
        if (abort_i) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (wrap && (pulses_q == '0)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          step_d = step_next_run;
          if (wrap) begin
            pulses_d = pulses_q - COUNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        pulses_d = '0;
        clr      = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pulses_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pulses_q  <= pulses_d;
    end
  end

  assign cmd_ready_o   = ready_q;
  assign step_o        = step_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign pulses_left_o = pulses_q;

endmodule

// File: tb/tb_step_pulse_sequencer.sv
// Directed and randomized trains checked against a cycle-index arithmetic model of the pulse schedule.
module tb_step_pulse_sequencer;

  localparam int PW = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_period_i;
  logic [15:0] cmd_count_i;
  logic        abort_i;
  logic        step_o;
  logic        busy_o;
  logic [15:0] pulses_left_o;
  logic        done_o;
  logic        aborted_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  step_pulse_sequencer #(.PERIOD_W(16), .COUNT_W(16), .PULSE_W(PW)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_period_i  (cmd_period_i),
    .cmd_count_i   (cmd_count_i),
    .abort_i       (abort_i),
    .step_o        (step_o),
    .busy_o        (busy_o),
    .pulses_left_o (pulses_left_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outs(input int st, input int bz, input int rd, input int dn, input int ab, input int pl);
    chk("step", 32'(step_o), 32'(st));
    chk("busy", 32'(busy_o), 32'(bz));
    chk("ready", 32'(cmd_ready_o), 32'(rd));
    chk("done", 32'(done_o), 32'(dn));
    chk("aborted", 32'(aborted_o), 32'(ab));
    chk("pulses_left", 32'(pulses_left_o), 32'(pl));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Cycle t counts from 1 = first cycle after the accepting edge.
  task automatic run_train(input int per, input int cnt, input int abort_at, input bit abort_on_accept,
                           input bit hold, input int nper, input int ncnt);
    int p, done_t;
    bit a_ok;
    p = (per < PW + 1) ? PW + 1 : per;
    chk("ready_before_cmd", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i  = 1'b1;
    cmd_period_i = 16'(per);
    cmd_count_i  = 16'(cnt);
    abort_i      = abort_on_accept;
    tick();
    abort_i = 1'b0;
    if (hold) begin
      cmd_period_i = 16'(nper);
      cmd_count_i  = 16'(ncnt);
    end else begin
      cmd_valid_i  = 1'b0;
      cmd_period_i = 16'($urandom);
      cmd_count_i  = 16'($urandom);
    end
    a_ok   = (cnt > 0) && (abort_at >= 1) && (abort_at <= cnt * p);
    done_t = a_ok ? abort_at + 1 : cnt * p + 1;
    for (int t = 1; t <= done_t + 1; t++) begin
      if (t < done_t)
        check_outs(((t - 1) % p) < PW, 1, 0, 0, 0, cnt - 1 - (t - 1) / p);
      else if (t == done_t)
        check_outs(0, 0, 0, 1, a_ok, a_ok ? cnt - 1 - (abort_at - 1) / p : 0);
      else
        check_outs(0, 0, 1, 0, 0, 0);
      abort_i = (t == abort_at);
      if (t <= done_t) tick();
    end
    abort_i = 1'b0;
  endtask

  initial begin
    int per, cnt, ab;
    reset_i      = 1'b1;
    cmd_valid_i  = 1'b0;
    abort_i      = 1'b0;
    cmd_period_i = '0;
    cmd_count_i  = '0;
    tick();
    tick();
    check_outs(0, 0, 1, 0, 0, 0);
    #2 reset_i = 1'b0;
    tick();
    check_outs(0, 0, 1, 0, 0, 0);

    run_train(5, 3, 0, 1'b0, 1'b0, 0, 0);
    run_train(5, 0, 0, 1'b0, 1'b0, 0, 0);
    run_train(1, 2, 0, 1'b0, 1'b0, 0, 0);
    run_train(10, 4, 12, 1'b0, 1'b0, 0, 0);
    run_train(4, 2, 0, 1'b1, 1'b0, 0, 0);
    // New command held valid through the whole train, then taken from IDLE.
    run_train(6, 2, 0, 1'b0, 1'b1, 3, 2);
    run_train(3, 2, 0, 1'b0, 1'b0, 0, 0);
    run_train(65535, 1, 3, 1'b0, 1'b0, 0, 0);

    // Asynchronous reset in the middle of a pulse.
    cmd_valid_i  = 1'b1;
    cmd_period_i = 16'd6;
    cmd_count_i  = 16'd3;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("step_before_reset", 32'(step_o), 32'd1);
    #2 reset_i = 1'b1;
    #1 check_outs(0, 0, 1, 0, 0, 0);
    tick();
    check_outs(0, 0, 1, 0, 0, 0);
    #2 reset_i = 1'b0;
    tick();
    run_train(4, 2, 0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      per = $urandom_range(0, 7);
      cnt = $urandom_range(0, 4);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
      run_train(per, cnt, ab, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
